// File: rtl/mod8_counter_pkg.sv
// Shared types and defaults for the modulo counter slice.
package mod8_counter_pkg;
    localparam int MOD8_WIDTH   = 3;
    localparam int MOD8_MODULUS = 8;

    typedef logic [MOD8_WIDTH-1:0] mod8_count_t;
endpackage

// File: rtl/mod8_counter_if.sv
// Control and count bundle between a counter and its driver.
interface mod8_counter_if
    import mod8_counter_pkg::*;
#(
    parameter int WIDTH = MOD8_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output en,
        output load,
        output load_val,
        input  q,
        input  tc
    );

    modport slave (
        input  en,
        input  load,
        input  load_val,
        output q,
        output tc
    );
endinterface

// File: rtl/mod8_counter_next.sv
// Next-count logic: clear beats load beats increment beats hold.
module mod8_counter_next
    import mod8_counter_pkg::*;
#(
    parameter int WIDTH   = MOD8_WIDTH,
    parameter int MODULUS = MOD8_MODULUS
) (
    input  logic [WIDTH-1:0] q,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q_next
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_red;
    logic [WIDTH:0]   load_ext;

    // Compare one bit wider so MODULUS == 2**WIDTH never truncates to 0.
    always_comb begin
        load_ext = {1'b0, load_val};
        load_red = load_val;
        if (load_ext >= (WIDTH+1)'(MODULUS))
            load_red = WIDTH'(load_ext - (WIDTH+1)'(MODULUS));
    end

    always_comb begin
        q_next = q;
        if (clr)
            q_next = '0;
        else if (load)
            q_next = load_red;
        else if (en)
            q_next = (q == LAST) ? '0 : q + WIDTH'(1);
    end
endmodule

// File: rtl/mod8_counter.sv
// Modulo-MODULUS up-counter with sync clear, load and terminal count.
module mod8_counter
    import mod8_counter_pkg::*;
#(
    parameter int WIDTH   = MOD8_WIDTH,
    parameter int MODULUS = MOD8_MODULUS
) (
    input  logic           clk,
    input  logic           clr,
    mod8_counter_if.slave  bus
);
    if (((1 << WIDTH) < MODULUS) || (MODULUS < 2)) begin : g_bad_params
        $error("mod8_counter: need 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;

    mod8_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q        (q_r),
        .clr      (clr),
        .load     (bus.load),
        .load_val (bus.load_val),
        .en       (bus.en),
        .q_next   (q_next)
    );

    always_ff @(posedge clk) begin
        q_r <= q_next;
    end

    assign bus.q  = q_r;
    assign bus.tc = (q_r == WIDTH'(MODULUS - 1));
endmodule

// File: tb/tb_mod8_counter.sv
// Scoreboard bench for mod8_counter at MODULUS 8 and 5.
module tb_mod8_counter;
    logic clk;
    logic clr8;
    logic clr5;

    int checks;
    int failures;

    typedef struct {
        int         u;
        logic [2:0] q;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];

    mod8_counter_if #(.WIDTH(3)) if8 ();
    mod8_counter_if #(.WIDTH(3)) if5 ();

    mod8_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk (clk),
        .clr (clr8),
        .bus (if8)
    );

    mod8_counter #(.WIDTH(3), .MODULUS(5)) dut5 (
        .clk (clk),
        .clr (clr5),
        .bus (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, pending=%0d", sb.size());
        $fatal(1, "timeout");
    end

    // Monitor: pops one expectation per cycle, compares on falling edge.
    initial begin
        exp_t e;
        logic [2:0] aq;
        logic atc;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                aq  = (e.u == 8) ? if8.q  : if5.q;
                atc = (e.u == 8) ? if8.tc : if5.tc;
                checks++;
                if (aq !== e.q || atc !== e.tc) begin
                    failures++;
                    $display("FAIL %s m%0d: got q=%0d tc=%b, want q=%0d tc=%b",
                             e.name, e.u, aq, atc, e.q, e.tc);
                end
            end
        end
    end

    // Drive one cycle of controls, then queue the expected registered result.
    task automatic step(input int u, input string name,
                        input logic c, input logic l,
                        input logic [2:0] lv, input logic e,
                        input logic [2:0] eq);
        exp_t x;
        @(negedge clk);
        if (u == 8) begin
            clr8 = c; if8.load = l; if8.load_val = lv; if8.en = e;
        end else begin
            clr5 = c; if5.load = l; if5.load_val = lv; if5.en = e;
        end
        @(posedge clk);
        x.u    = u;
        x.q    = eq;
        x.tc   = (int'(eq) == u - 1);
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic run(input int u, input string name, input logic e,
                       input int n, input logic [2:0] start);
        logic [2:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            v = (int'(v) == u - 1) ? 3'd0 : v + 3'd1;
            step(u, name, 1'b0, 1'b0, 3'd0, e, e ? v : start);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clr8 = 1'b0; if8.en = 1'b0; if8.load = 1'b0; if8.load_val = '0;
        clr5 = 1'b0; if5.en = 1'b0; if5.load = 1'b0; if5.load_val = '0;

        // MODULUS = 8
        step(8, "reset", 1, 0, 3'd0, 0, 3'd0);
        step(8, "run1", 0, 0, 3'd0, 1, 3'd1);
        step(8, "run2", 0, 0, 3'd0, 1, 3'd2);
        step(8, "run3", 0, 0, 3'd0, 1, 3'd3);
        step(8, "run4", 0, 0, 3'd0, 1, 3'd4);
        step(8, "run5", 0, 0, 3'd0, 1, 3'd5);
        step(8, "run6", 0, 0, 3'd0, 1, 3'd6);
        step(8, "run7", 0, 0, 3'd0, 1, 3'd7);
        step(8, "wrap0", 0, 0, 3'd0, 1, 3'd0);
        step(8, "wrap1", 0, 0, 3'd0, 1, 3'd1);
        step(8, "wrap2", 0, 0, 3'd0, 1, 3'd2);
        step(8, "midclr", 1, 0, 3'd0, 1, 3'd0);
        step(8, "aftclr1", 0, 0, 3'd0, 1, 3'd1);
        step(8, "aftclr2", 0, 0, 3'd0, 1, 3'd2);
        run(8, "to5", 1, 3, 3'd2);
        step(8, "hold", 0, 0, 3'd0, 0, 3'd5);
        step(8, "hold", 0, 0, 3'd0, 0, 3'd5);
        step(8, "hold", 0, 0, 3'd0, 0, 3'd5);
        step(8, "unhold", 0, 0, 3'd0, 1, 3'd6);
        step(8, "load6", 0, 1, 3'd6, 1, 3'd6);
        step(8, "ld_inc7", 0, 0, 3'd0, 1, 3'd7);
        step(8, "ld_wrap", 0, 0, 3'd0, 1, 3'd0);
        step(8, "prio_clr", 1, 1, 3'd3, 1, 3'd0);
        step(8, "prio_ld", 0, 1, 3'd3, 1, 3'd3);
        step(8, "load7", 0, 1, 3'd7, 0, 3'd7);
        step(8, "tc_hold", 0, 0, 3'd0, 0, 3'd7);
        step(8, "tc_hold", 0, 0, 3'd0, 0, 3'd7);
        step(8, "tc_wrap", 0, 0, 3'd0, 1, 3'd0);

        // MODULUS = 5
        step(5, "m5_clr", 1, 0, 3'd0, 0, 3'd0);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd1);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd2);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd3);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd4);
        step(5, "m5_wrap", 0, 0, 3'd0, 1, 3'd0);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd1);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd2);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd3);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd4);
        step(5, "m5_wrap", 0, 0, 3'd0, 1, 3'd0);
        step(5, "m5_r", 0, 0, 3'd0, 1, 3'd1);
        step(5, "m5_ld6", 0, 1, 3'd6, 0, 3'd1);
        step(5, "m5_ld7", 0, 1, 3'd7, 1, 3'd2);
        step(5, "m5_ld5", 0, 1, 3'd5, 0, 3'd0);
        step(5, "m5_ld4", 0, 1, 3'd4, 0, 3'd4);
        step(5, "m5_hold", 0, 0, 3'd0, 0, 3'd4);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
